// File: rtl/wb_gpio_altfunc_if.sv
// Wishbone classic slave bus bundle for wb_gpio_altfunc.
//   wb_adr_i  5-bit byte address ([4:2] selects a register)
//   wb_dat_i  32-bit write data
//   wb_dat_o  32-bit read data
//   wb_sel_i  4 byte enables
//   wb_we_i   write enable
//   wb_cyc_i  bus cycle
//   wb_stb_i  strobe
//   wb_ack_o  acknowledge
// Modports: master (SoC side) drives the request, slave (GPIO) answers.
interface wb_gpio_altfunc_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_gpio_altfunc.sv
// wb_gpio_altfunc: Wishbone-slave GPIO controller with per-pin direction,
// output data and alternate-function ownership. Pad inputs are synchronized
// and optionally edge-detected into an interrupt.
//
// Build option: define GPIO_IRQ_EN to include the MASK/EDGE/PEND registers
// and the edge-detect interrupt. Without it irq_o is tied low and
// 0x10..0x18 read as zero.
//
// Ports:
//   clock    system / Wishbone clock
//   reset    synchronous, active-high
//   wb       Wishbone slave bundle (wb_gpio_altfunc_if.slave)
//   gpio_i   asynchronous pad inputs
//   gpio_o   pad output values
//   gpio_oe  pad output enables, 1 = drive
//   alt_o    alternate-function output per pin
//   alt_oe   alternate-function output enable per pin
//   alt_i    synchronized pad inputs for peripherals
//   irq_o    interrupt request
//
// Register map (word index = wb_adr_i[4:2]):
//   0 IN  RO | 1 OUT | 2 DIR | 3 ALT | 4 MASK | 5 EDGE | 6 PEND (W1C) | 7 zero
module wb_gpio_altfunc #(
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  wb_gpio_altfunc_if.slave      wb,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  input  logic [GPIO_WIDTH-1:0] alt_o,
  input  logic [GPIO_WIDTH-1:0] alt_oe,
  output logic [GPIO_WIDTH-1:0] alt_i,
  output logic                  irq_o
);

  logic                  ack_reg;
  logic [31:0]           dat_reg;
  logic [31:0]           rd_data;
  logic [GPIO_WIDTH-1:0] out_reg, dir_reg, alt_reg;
  logic [GPIO_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] in_val;
  logic [GPIO_WIDTH-1:0] wmask;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [2:0]            reg_sel;
  logic                  access;
  logic                  wr;

  // Byte-lane and address-LSB bits that have no effect for narrow builds.
  logic unused_bits;
  assign unused_bits = &{1'b0, wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[1:0]};

  // A new access is accepted only while ack is low, giving one wait state
  // and a guaranteed idle cycle between back-to-back accesses.
  assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_reg;
  assign wr      = access & wb.wb_we_i;
  assign reg_sel = wb.wb_adr_i[4:2];
  assign wdata   = wb.wb_dat_i[GPIO_WIDTH-1:0];

  // Per-bit write enable from the byte lane covering that bit.
  genvar gi;
  generate
    for (gi = 0; gi < GPIO_WIDTH; gi++) begin : g_wmask
      assign wmask[gi] = wb.wb_sel_i[gi/8];
    end
  endgenerate

  function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] cur);
    return (cur & ~wmask) | (wdata & wmask);
  endfunction

  // Input synchronizer; the last stage is the architectural pin state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
    end else begin
      sync_reg[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  assign in_val = sync_reg[SYNC_STAGES-1];
  assign alt_i  = in_val;

  // Pad mux: ALT hands both value and enable to the peripheral.
  assign gpio_o  = (alt_reg & alt_o)  | (~alt_reg & out_reg);
  assign gpio_oe = (alt_reg & alt_oe) | (~alt_reg & dir_reg);

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] mask_reg, edge_reg, pend_reg, prev_reg;
  logic [GPIO_WIDTH-1:0] hit, clr;
  logic                  irq_reg;

  assign hit = (edge_reg & in_val & ~prev_reg) | (~edge_reg & ~in_val & prev_reg);
  assign clr = (wr && reg_sel == 3'd6) ? (wdata & wmask) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      mask_reg <= '0;
      edge_reg <= '0;
      pend_reg <= '0;
      prev_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      prev_reg <= in_val;
      // Set wins over a simultaneous W1C on the same bit.
      pend_reg <= (pend_reg & ~clr) | hit;
      irq_reg  <= |(pend_reg & mask_reg);
      if (wr && reg_sel == 3'd4) mask_reg <= merge(mask_reg);
      if (wr && reg_sel == 3'd5) edge_reg <= merge(edge_reg);
    end
  end

  assign irq_o = irq_reg;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd0: rd_data[GPIO_WIDTH-1:0] = in_val;
      3'd1: rd_data[GPIO_WIDTH-1:0] = out_reg;
      3'd2: rd_data[GPIO_WIDTH-1:0] = dir_reg;
      3'd3: rd_data[GPIO_WIDTH-1:0] = alt_reg;
`ifdef GPIO_IRQ_EN
      3'd4: rd_data[GPIO_WIDTH-1:0] = mask_reg;
      3'd5: rd_data[GPIO_WIDTH-1:0] = edge_reg;
      3'd6: rd_data[GPIO_WIDTH-1:0] = pend_reg;
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
      out_reg <= '0;
      dir_reg <= '0;
      alt_reg <= '0;
    end else begin
      ack_reg <= access;
      dat_reg <= access ? rd_data : '0;
      if (wr && reg_sel == 3'd1) out_reg <= merge(out_reg);
      if (wr && reg_sel == 3'd2) dir_reg <= merge(dir_reg);
      if (wr && reg_sel == 3'd3) alt_reg <= merge(alt_reg);
    end
  end

  assign wb.wb_ack_o = ack_reg;
  assign wb.wb_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_gpio_altfunc.sv
// Testbench for wb_gpio_altfunc: directed register/pad/latency/reset cases
// followed by randomized bus traffic and pad changes, checked against a
// register-level model. Read data is checked by a scoreboard monitor that
// pops one expectation per ack.
module tb_wb_gpio_altfunc;
  localparam int W = 8;
  localparam int S = 3;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_gpio_altfunc_if wb();
  logic [W-1:0] gpio_i, gpio_o, gpio_oe, alt_o, alt_oe, alt_i;
  logic         irq_o;

  wb_gpio_altfunc #(.GPIO_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clock  (clock),
    .reset  (reset),
    .wb     (wb),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .alt_o  (alt_o),
    .alt_oe (alt_oe),
    .alt_i  (alt_i),
    .irq_o  (irq_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: register contents and the settled pad value.
  logic [W-1:0] out_m, dir_m, alt_m, mask_m, edge_m, pend_m, pad_m;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    logic [4:0]  adr;
  } sb_t;
  sb_t sb_q[$];

  function automatic logic [W-1:0] apply_bytes(input logic [W-1:0] old, input logic [31:0] dat,
                                               input logic [3:0] sel);
    logic [31:0] r;
    r = 32'(old);
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r[W-1:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] adr);
    logic [W-1:0] v;
    case (adr[4:2])
      3'd0: v = pad_m;
      3'd1: v = out_m;
      3'd2: v = dir_m;
      3'd3: v = alt_m;
      3'd4: v = IRQ ? mask_m : '0;
      3'd5: v = IRQ ? edge_m : '0;
      3'd6: v = IRQ ? pend_m : '0;
      default: v = '0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    case (adr[4:2])
      3'd1: out_m = apply_bytes(out_m, dat, sel);
      3'd2: dir_m = apply_bytes(dir_m, dat, sel);
      3'd3: alt_m = apply_bytes(alt_m, dat, sel);
      3'd4: if (IRQ) mask_m = apply_bytes(mask_m, dat, sel);
      3'd5: if (IRQ) edge_m = apply_bytes(edge_m, dat, sel);
      3'd6: if (IRQ) pend_m = pend_m & ~apply_bytes('0, dat, sel);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    out_m = '0; dir_m = '0; alt_m = '0; mask_m = '0; edge_m = '0; pend_m = '0;
  endtask

  // Record the edges a pad change will produce, given the current EDGE setting.
  task automatic model_pad(input logic [W-1:0] v);
    if (IRQ) pend_m = pend_m | (edge_m & v & ~pad_m) | (~edge_m & ~v & pad_m);
    pad_m = v;
  endtask

  // One Wishbone access; called just after a rising edge.
  task automatic bus(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel, input bit we);
    sb_t e;
    bit got;
    e.is_read = !we;
    e.data    = model_read(adr);
    e.adr     = adr;
    sb_q.push_back(e);
    wb.wb_adr_i = adr; wb.wb_dat_i = dat; wb.wb_sel_i = sel; wb.wb_we_i = we;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (wb.wb_ack_o) begin got = 1'b1; break; end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    if (!got) begin
      check("ack_timeout", 32'(got), 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end else if (we) begin
      model_write(adr, dat, sel);
    end
    @(posedge clock); #1;
  endtask

  task automatic set_pad(input logic [W-1:0] v);
    model_pad(v);
    gpio_i = v;
    repeat (S + 3) @(posedge clock);
    #1;
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_gpio_o"},  32'(gpio_o),  32'((alt_m & alt_o) | (~alt_m & out_m)));
    check({tag, "_gpio_oe"}, 32'(gpio_oe), 32'((alt_m & alt_oe) | (~alt_m & dir_m)));
    check({tag, "_alt_i"},   32'(alt_i),   32'(pad_m));
    check({tag, "_irq"},     32'(irq_o),   32'(IRQ ? |(pend_m & mask_m) : 1'b0));
  endtask

  // Scoreboard monitor: one expectation per ack, ack one cycle wide.
  bit prev_ack = 1'b0;
  always @(negedge clock) begin
    if (wb.wb_ack_o) begin
      check("ack_single", 32'(prev_ack), 32'd0);
      if (sb_q.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.is_read) begin
          $display("read  adr=0x%02h data=0x%08h exp=0x%08h", e.adr, wb.wb_dat_o, e.data);
          check($sformatf("read_%02h", e.adr), wb.wb_dat_o, e.data);
        end else begin
          $display("write adr=0x%02h acked", e.adr);
        end
      end
    end else if (prev_ack) begin
      check("dat_idle", wb.wb_dat_o, 32'd0);
    end
    prev_ack = wb.wb_ack_o;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0; wb.wb_we_i = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    gpio_i = '0; alt_o = '0; alt_oe = '0;
    pad_m = '0;
    model_reset();

    // 1. Reset state
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (S + 2) @(posedge clock);
    #1;
    check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    check("rst_gpio_o", 32'(gpio_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    bus(5'h04, 32'd0, 4'hF, 1'b0);
    bus(5'h08, 32'd0, 4'hF, 1'b0);
    bus(5'h0C, 32'd0, 4'hF, 1'b0);

    // 2. DIR/OUT writes and byte-enable gating
    bus(5'h08, 32'hFF, 4'b0001, 1'b1);
    bus(5'h04, 32'hA5, 4'b0001, 1'b1);
    check("t2_oe", 32'(gpio_oe), 32'hFF);
    check("t2_out", 32'(gpio_o), 32'hA5);
    bus(5'h04, 32'h5A00, 4'b0010, 1'b1);
    check("t2_sel_out", 32'(gpio_o), 32'hA5);
    bus(5'h04, 32'd0, 4'hF, 1'b0);

    // 3. Alternate function ownership
    bus(5'h0C, 32'h02, 4'b0001, 1'b1);
    bus(5'h08, 32'h00, 4'b0001, 1'b1);
    alt_o = 8'h02; alt_oe = 8'h02;
    #1;
    check("t3_oe", 32'(gpio_oe), 32'h02);
    check("t3_out", 32'(gpio_o), 32'hA7);
    check_pins("t3");
    bus(5'h0C, 32'h00, 4'b0001, 1'b1);
    check("t3_revert_oe", 32'(gpio_oe), 32'h00);
    check("t3_revert_out", 32'(gpio_o), 32'hA5);

    // 4. Synchronizer latency
    gpio_i = 8'h08;
    model_pad(8'h08);
    for (int k = 1; k <= S; k++) begin
      @(posedge clock); #1;
      check($sformatf("t4_lat%0d", k), 32'(alt_i[3]), 32'(k == S));
    end
    repeat (2) @(posedge clock);
    #1;
    bus(5'h00, 32'd0, 4'hF, 1'b0);

`ifdef GPIO_IRQ_EN
    // 5. Edge interrupt, W1C, and set-wins collision
    set_pad(8'h00);
    bus(5'h18, 32'hFF, 4'hF, 1'b1);
    bus(5'h10, 32'h08, 4'b0001, 1'b1);
    bus(5'h14, 32'h08, 4'b0001, 1'b1);
    set_pad(8'h08);
    set_pad(8'h00);
    check("t5_irq_set", 32'(irq_o), 32'd1);
    bus(5'h18, 32'd0, 4'hF, 1'b0);
    bus(5'h18, 32'h08, 4'b0001, 1'b1);
    check("t5_irq_clr", 32'(irq_o), 32'd0);
    check_pins("t5a");
    gpio_i = 8'h08;
    repeat (S) @(posedge clock);
    #1;
    bus(5'h18, 32'h08, 4'b0001, 1'b1);
    model_pad(8'h08);
    check("t5_collide_irq", 32'(irq_o), 32'd1);
    bus(5'h18, 32'd0, 4'hF, 1'b0);
    bus(5'h18, 32'hFF, 4'hF, 1'b1);
    set_pad(8'h00);
    check_pins("t5b");
`endif

    // 6. Reset in the middle of a write
    set_pad(8'h00);
    bus(5'h04, 32'hA5, 4'hF, 1'b1);
    wb.wb_adr_i = 5'h04; wb.wb_dat_i = 32'h33; wb.wb_sel_i = 4'hF; wb.wb_we_i = 1'b1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("t6_no_ack", 32'(wb.wb_ack_o), 32'd0);
    reset = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    model_reset();
    @(posedge clock); #1;
    check("t6_no_ack2", 32'(wb.wb_ack_o), 32'd0);
    repeat (S + 2) @(posedge clock);
    #1;
    check_pins("t6");
    bus(5'h04, 32'd0, 4'hF, 1'b0);
    bus(5'h04, 32'h3C, 4'hF, 1'b1);
    bus(5'h04, 32'd0, 4'hF, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      alt_o  = W'($urandom);
      alt_oe = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        set_pad(W'($urandom));
      end else begin
        r_adr = 5'($urandom);
        r_dat = $urandom;
        r_sel = 4'($urandom);
        bus(r_adr, r_dat, r_sel, 1'($urandom_range(0, 1)));
      end
      check_pins($sformatf("rnd%0d", n));
    end

    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
